// File: rtl/da_platform.sv
// Shared serial-interface platform constants: shift-FSM state encoding,
// serializer defaults and a counter-width helper.
package da_platform;

   localparam logic SER_ST_IDLE  = 1'b0;
   localparam logic SER_ST_SHIFT = 1'b1;

   typedef enum logic {
      ST_IDLE  = SER_ST_IDLE,
      ST_SHIFT = SER_ST_SHIFT
   } ser_state_e;

   localparam int SER_NB_DEFAULT = 8;
   localparam int SER_ND_DEFAULT = 2;

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bitclk_gen.sv
// Bit-clock generator: phase counter over Nd clk cycles, toggling sclk on
// every wrap and flagging the cycles in which sclk is about to rise or fall.
module bitclk_gen
   import da_platform::*;
#(
   parameter int Nd = SER_ND_DEFAULT
)(
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int PW = cnt_width(Nd);

   logic [PW-1:0] phase_q, phase_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   assign wrap = en_i && (phase_q == PW'(Nd - 1));

   always_comb begin
      phase_d = phase_q;
      sclk_d  = sclk_q;
      if (!en_i) begin
         phase_d = '0;
      end else if (wrap) begin
         phase_d = '0;
         sclk_d  = ~sclk_q;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= '0;
         sclk_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = wrap && !sclk_q;
   assign fall_o = wrap &&  sclk_q;

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: MSB-first shift-out with bit clock, frame
// marker on the MSB and seamless back-to-back words.
module serializer
   import da_platform::*;
#(
   parameter int Nb         = SER_NB_DEFAULT,
   parameter int Nd         = SER_ND_DEFAULT,
   parameter bit idle_level = 1'b0
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [Nb-1:0] data_in,
   input  logic          data_valid,
   output logic          data_ready,
   output logic          sdata,
   output logic          sclk,
   output logic          frame,
   output logic          busy
);

   localparam int BW = cnt_width(Nb);

   ser_state_e    state_q, state_d;
   logic [Nb-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          frame_q, frame_d;
   logic          run, rise, fall, last_fall, xfer;

   assign run = (state_q == ST_SHIFT);

   bitclk_gen #(.Nd(Nd)) u_bitclk (
      .clk    (clk),
      .reset  (reset),
      .en_i   (run),
      .sclk_o (sclk),
      .rise_o (rise),
      .fall_o (fall)
   );

   // The final clk cycle of the final bit is the only in-flight accept slot.
   assign last_fall  = fall && (bit_q == BW'(Nb - 1));
   assign data_ready = !reset && ((state_q == ST_IDLE) || last_fall);
   assign xfer       = data_valid && data_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_SHIFT;
               shreg_d = data_in;
               bit_d   = '0;
               frame_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               frame_d = 1'b0;
               if (last_fall) begin
                  bit_d = '0;
                  if (xfer) begin
                     shreg_d = data_in;
                     frame_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     shreg_d = '0;
                  end
               end else begin
                  shreg_d = {shreg_q[Nb-2:0], 1'b0};
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
      end
   end

   // A rise strobe outside SHIFT, or coinciding with a fall, means the
   // phase counter and the FSM have drifted apart.
   always_ff @(posedge clk) begin
      if (!reset && rise) assert (run && !fall);
   end

   assign sdata = run ? shreg_q[Nb-1] : idle_level;
   assign frame = frame_q;
   assign busy  = run;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: table-driven Nb=4/Nd=1 sequence plus directed and
// random Nb=8/Nd=2 traffic checked against a position-based reference model.
module tb_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nbad = 0;

   // u0 (idle_level 0) and u2 (idle_level 1) share one stimulus stream
   logic       rst, vld;
   logic [7:0] din;
   logic       r0, s0, k0, f0, b0;
   logic       r2, s2, k2, f2, b2;
   logic       rst1, vld1;
   logic [3:0] din1;
   logic       r1, s1, k1, f1, b1;

   serializer #(.Nb(8), .Nd(2), .idle_level(1'b0)) u0 (
      .clk(clk), .reset(rst), .data_in(din), .data_valid(vld),
      .data_ready(r0), .sdata(s0), .sclk(k0), .frame(f0), .busy(b0));
   serializer #(.Nb(8), .Nd(2), .idle_level(1'b1)) u2 (
      .clk(clk), .reset(rst), .data_in(din), .data_valid(vld),
      .data_ready(r2), .sdata(s2), .sclk(k2), .frame(f2), .busy(b2));
   serializer #(.Nb(4), .Nd(1), .idle_level(1'b0)) u1 (
      .clk(clk), .reset(rst1), .data_in(din1), .data_valid(vld1),
      .data_ready(r1), .sdata(s1), .sclk(k1), .frame(f1), .busy(b1));

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: rdy/sd/sck/frm/bsy got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: a word in flight and its position (clk cycles since
   // its first bit cycle); outputs follow from Nb=8, Nd=2 arithmetic.
   bit         m_on = 1'b0;
   logic [7:0] m_word = '0;
   int         m_p = 0;
   int         n_rise = 0, n_busy = 0, n_frame = 0;
   logic       k0_prev = 1'b0;

   task automatic cyc(input logic r, input logic v, input logic [7:0] d, input string tag);
      logic [4:0] e0, e2;
      logic       er;
      rst = r; vld = v; din = d;
      #1;
      er = r ? 1'b0 : (!m_on || m_p == 31);
      if (m_on) e0 = {er, m_word[7 - m_p / 4], (m_p % 4) >= 2, m_p < 4, 1'b1};
      else      e0 = {er, 4'b0000};
      e2 = e0;
      if (!m_on) e2[3] = 1'b1;
      chk(tag, {r0, s0, k0, f0, b0}, e0);
      chk({tag, "/idle1"}, {r2, s2, k2, f2, b2}, e2);
      if (k0 && !k0_prev) n_rise++;
      if (b0) n_busy++;
      if (f0) n_frame++;
      k0_prev = k0;
      @(posedge clk);
      if (r) m_on = 1'b0;
      else begin
         if (m_on) begin
            m_p++;
            if (m_p == 32) m_on = 1'b0;
         end
         if (v && er) begin
            m_on = 1'b1; m_word = d; m_p = 0;
         end
      end
      #1;
   endtask

   task automatic idle_n(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom), tag);
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [3:0] d;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[19];

   initial begin
      // {reset, valid, data_in, expected {rdy,sdata,sclk,frame,busy}}
      tbl[0]  = '{1'b1, 1'b1, 4'h9, 5'b00000};
      tbl[1]  = '{1'b0, 1'b1, 4'h9, 5'b10000};
      tbl[2]  = '{1'b0, 1'b0, 4'h0, 5'b01011};
      tbl[3]  = '{1'b0, 1'b0, 4'h9, 5'b01111};
      tbl[4]  = '{1'b0, 1'b0, 4'h3, 5'b00001};
      tbl[5]  = '{1'b0, 1'b1, 4'hF, 5'b00101};
      tbl[6]  = '{1'b0, 1'b0, 4'h0, 5'b00001};
      tbl[7]  = '{1'b0, 1'b0, 4'h0, 5'b00101};
      tbl[8]  = '{1'b0, 1'b0, 4'h0, 5'b01001};
      tbl[9]  = '{1'b0, 1'b1, 4'h6, 5'b11101};
      tbl[10] = '{1'b0, 1'b0, 4'h0, 5'b00011};
      tbl[11] = '{1'b0, 1'b0, 4'h0, 5'b00111};
      tbl[12] = '{1'b0, 1'b0, 4'h0, 5'b01001};
      tbl[13] = '{1'b0, 1'b0, 4'h0, 5'b01101};
      tbl[14] = '{1'b0, 1'b0, 4'h0, 5'b01001};
      tbl[15] = '{1'b0, 1'b0, 4'h0, 5'b01101};
      tbl[16] = '{1'b0, 1'b0, 4'h0, 5'b00001};
      tbl[17] = '{1'b0, 1'b0, 4'h0, 5'b10101};
      tbl[18] = '{1'b0, 1'b0, 4'h0, 5'b10000};

      rst = 1'b1; vld = 1'b0; din = '0;
      rst1 = 1'b1; vld1 = 1'b0; din1 = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         rst1 = tbl[i].r; vld1 = tbl[i].v; din1 = tbl[i].d;
         #1;
         chk($sformatf("nb4nd1[%0d]", i), {r1, s1, k1, f1, b1}, tbl[i].exp);
         @(posedge clk);
         #1;
      end
      rst1 = 1'b1;

      cyc(1'b1, 1'b1, 8'h5A, "reset");
      cyc(1'b1, 1'b0, 8'h00, "reset");
      idle_n(20, "idle20");

      n_rise = 0; n_busy = 0; n_frame = 0;
      cyc(1'b0, 1'b1, 8'hA5, "a5_xfer");
      idle_n(34, "a5_word");
      chk_n("a5_sclk_rises", n_rise, 8);
      chk_n("a5_busy_cycles", n_busy, 32);
      chk_n("a5_frame_cycles", n_frame, 4);

      cyc(1'b0, 1'b1, 8'hA5, "b2b_xfer");
      for (int i = 1; i <= 32; i++) cyc(1'b0, 1'b1, 8'h3C, "b2b_hold");
      idle_n(34, "b2b_tail");

      cyc(1'b0, 1'b1, 8'hFF, "rst_ff_xfer");
      idle_n(9, "rst_ff_word");
      cyc(1'b1, 1'b0, 8'h00, "rst_mid");
      cyc(1'b0, 1'b1, 8'h81, "rst_81_xfer");
      idle_n(34, "rst_81_word");

      cyc(1'b0, 1'b1, 8'h00, "zero_xfer");
      idle_n(34, "zero_word");

      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(99) == 0, $urandom_range(3) != 0, 8'($urandom), "random");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
